// File: rtl/xorshift_pkg.sv
// ============================================================================
// xorshift_pkg
//   Shared xorshift32 (13/17/5) step, shift constants and checker state type.
//   Rev 1.0
// ============================================================================
`default_nettype none

package xorshift_pkg;

  localparam int unsigned XS_SH_A = 13;
  localparam int unsigned XS_SH_B = 17;
  localparam int unsigned XS_SH_C = 5;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } xs_chk_state_t;

  function automatic logic [31:0] xs32_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << XS_SH_A);
    t = t ^ (t >> XS_SH_B);
    t = t ^ (t << XS_SH_C);
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xorshift32_checker.sv
// ============================================================================
// xorshift32_checker
//   Self-synchronising receive checker for the xorshift32 stream.
//   Rev 1.0
// ============================================================================
`default_nettype none

module xorshift32_checker
  import xorshift_pkg::*;
#(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [31:0]      din,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic             zero_seen,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] match_count
);

  localparam int c_RUN_MAX = (LOCK_COUNT > UNLOCK_ERRS) ? LOCK_COUNT : UNLOCK_ERRS;
  localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);
  localparam logic [c_RUN_W-1:0] c_LOCK_RUN   = c_RUN_W'(LOCK_COUNT);
  localparam logic [c_RUN_W-1:0] c_UNLOCK_RUN = c_RUN_W'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;

  xs_chk_state_t        state_q, state_d;
  logic [31:0]          pred_q, pred_d;
  logic [c_RUN_W-1:0]   run_q, run_d;
  logic                 locked_q, locked_d;
  logic                 pulse_q, pulse_d;
  logic                 zero_q, zero_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     match_q, match_d;

  logic [31:0]          w_din_next;
  logic [31:0]          w_pred_next;
  logic [c_RUN_W-1:0]   w_run_inc;
  logic                 w_din_zero;
  logic                 w_match;

  assign w_din_next  = xs32_next(din);
  assign w_pred_next = xs32_next(pred_q);
  assign w_run_inc   = run_q + c_RUN_W'(1);
  assign w_din_zero  = (din == 32'd0);
  assign w_match     = (din == pred_q) && !w_din_zero;

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    run_d   = run_q;
    zero_d  = zero_q;
    pulse_d = 1'b0;
    err_d   = err_q;
    match_d = match_q;

    if (din_valid) begin
      case (state_q)
        SEED: begin
          if (w_din_zero) begin
            zero_d = 1'b1;
          end else begin
            pred_d  = w_din_next;
            run_d   = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (w_din_zero) begin
            zero_d  = 1'b1;
            run_d   = '0;
            state_d = SEED;
          end else if (w_match) begin
            pred_d = w_din_next;
            if (w_run_inc == c_LOCK_RUN) begin
              run_d   = '0;
              state_d = LOCKED;
            end else begin
              run_d = w_run_inc;
            end
          end else begin
            pred_d = w_din_next;
            run_d  = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances whether or not the word matched.
          pred_d = w_pred_next;
          if (w_din_zero) zero_d = 1'b1;
          if (w_match) begin
            run_d = '0;
            if (match_q != c_CNT_MAX) match_d = match_q + CNT_W'(1);
          end else begin
            pulse_d = 1'b1;
            if (err_q != c_CNT_MAX) err_d = err_q + CNT_W'(1);
            if (w_run_inc == c_UNLOCK_RUN) begin
              run_d   = '0;
              state_d = SEED;
            end else begin
              run_d = w_run_inc;
            end
          end
        end
        default: begin
          run_d   = '0;
          state_d = SEED;
        end
      endcase
    end

    if (clear_counts) begin
      err_d   = '0;
      match_d = '0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= SEED;
      pred_q   <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= '0;
      match_q  <= '0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      match_q  <= match_d;
    end
  end

  assign locked      = locked_q;
  assign err_pulse   = pulse_q;
  assign zero_seen   = zero_q;
  assign err_count   = err_q;
  assign match_count = match_q;

`ifdef FORMAL
  logic past_valid_q;
  always_ff @(posedge clock) past_valid_q <= 1'b1;

  a_locked_state: assert property (@(posedge clock) locked |-> (state_q == LOCKED));
  a_pulse_locked: assert property (@(posedge clock)
    (past_valid_q && err_pulse) |-> $past(locked));
  a_err_mono: assert property (@(posedge clock)
    (past_valid_q && $past(reset) && !$past(clear_counts)) |-> (err_count >= $past(err_count)));
  a_match_mono: assert property (@(posedge clock)
    (past_valid_q && $past(reset) && !$past(clear_counts)) |-> (match_count >= $past(match_count)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_xorshift32_checker.sv
// ============================================================================
// tb_xorshift32_checker
//   Randomised and directed checking of xorshift32_checker against a model.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_xorshift32_checker;

  localparam int CNT_W = 5;
  localparam int LC    = 4;
  localparam int UE    = 3;
  localparam int c_SAT = (1 << CNT_W) - 1;
  localparam int M_SEED = 0, M_SYNC = 1, M_LOCK = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             din_valid = 1'b0;
  logic [31:0]      din = '0;
  logic             clear_counts = 1'b0;
  logic             locked, err_pulse, zero_seen;
  logic [CNT_W-1:0] err_count, match_count;

  xorshift32_checker #(.LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .CNT_W(CNT_W)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .clear_counts(clear_counts),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .zero_seen   (zero_seen),
    .err_count   (err_count),
    .match_count (match_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_state = M_SEED;
  logic [31:0] m_pred  = '0;
  int          m_run   = 0;
  bit          m_pulse = 0;
  bit          m_zero  = 0;
  int          m_ec    = 0;
  int          m_mc    = 0;
  logic [31:0] g;

  function automatic logic [31:0] nx(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit v, input logic [31:0] w, input bit clr, input bit rn);
    m_pulse = 0;
    if (!rn) begin
      m_state = M_SEED; m_pred = 0; m_run = 0; m_zero = 0; m_ec = 0; m_mc = 0;
      return;
    end
    if (v) begin
      if (m_state == M_SEED) begin
        if (w == 0) m_zero = 1;
        else begin m_pred = nx(w); m_run = 0; m_state = M_SYNC; end
      end else if (m_state == M_SYNC) begin
        if (w == 0) begin m_zero = 1; m_state = M_SEED; m_run = 0; end
        else if (w == m_pred) begin
          m_pred = nx(w);
          m_run++;
          if (m_run == LC) begin m_state = M_LOCK; m_run = 0; end
        end else begin m_pred = nx(w); m_run = 0; end
      end else begin
        if (w == 0) m_zero = 1;
        if (w != 0 && w == m_pred) begin
          m_run = 0;
          if (m_mc < c_SAT) m_mc++;
        end else begin
          m_pulse = 1;
          if (m_ec < c_SAT) m_ec++;
          m_run++;
          if (m_run == UE) begin m_state = M_SEED; m_run = 0; end
        end
        m_pred = nx(m_pred);
      end
    end
    if (clr) begin m_ec = 0; m_mc = 0; end
  endtask

  task automatic cyc(input bit v, input logic [31:0] w, input bit clr, input bit rn);
    @(negedge clock);
    din_valid = v; din = w; clear_counts = clr; reset = rn;
    @(posedge clock);
    model(v, w, clr, rn);
    #1;
    chk("locked", locked, (m_state == M_LOCK));
    chk("err_pulse", err_pulse, m_pulse);
    chk("zero_seen", zero_seen, m_zero);
    chk("err_count", err_count, m_ec);
    chk("match_count", match_count, m_mc);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, g, 0, 1);
      g = nx(g);
    end
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_locked", locked, 0);

    // Clean stream seeded at 1: lock after the 5th word
    g = 32'd1;
    clean(4);
    chk("pre_lock", locked, 0);
    clean(1);
    chk("lock5", locked, 1);
    chk("lock5_mc", match_count, 0);
    clean(3);
    chk("mc3", match_count, 3);

    // Single corrupted word
    cyc(1, g ^ 32'd1, 0, 1); g = nx(g);
    chk("corr_pulse", err_pulse, 1);
    chk("corr_ec", err_count, 1);
    chk("corr_locked", locked, 1);
    clean(1);
    chk("corr_after", err_pulse, 0);
    chk("corr_mc", match_count, 4);

    // Different seed: 3 errors then relock after 5 more words
    g = 32'h1234_5678;
    clean(2);
    chk("sw_locked2", locked, 1);
    clean(1);
    chk("sw_pulse3", err_pulse, 1);
    chk("sw_unlock", locked, 0);
    chk("sw_ec", err_count, 4);
    clean(4);
    chk("sw_notyet", locked, 0);
    clean(1);
    chk("sw_relock", locked, 1);

    // Valid gaps (1-0-0-1)
    cyc(1, 0, 0, 0);
    g = 32'd1;
    for (int i = 0; i < 5; i++) begin
      clean(1);
      if (i == 3) chk("gap_pre", locked, 0);
      cyc(0, $urandom, 0, 1);
      cyc(0, $urandom, 0, 1);
    end
    chk("gap_lock", locked, 1);
    chk("gap_ec", err_count, 0);

    // Zero word in SEED
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("zero_seen", zero_seen, 1);
    g = 32'hCAFE_0001;
    clean(5);
    chk("zero_then_lock", locked, 1);

    // clear_counts coincident with a mismatch
    clean(2);
    cyc(1, g ^ 32'h8000_0000, 1, 1); g = nx(g);
    chk("clr_ec", err_count, 0);
    chk("clr_mc", match_count, 0);
    chk("clr_pulse", err_pulse, 1);

    // Reset while locked
    clean(3);
    cyc(1, g, 0, 0); g = nx(g);
    chk("rst_unlock", locked, 0);
    chk("rst_mc", match_count, 0);
    clean(5);
    chk("rst_relock", locked, 1);

    // Saturation
    clean(40);
    chk("sat_mc", match_count, c_SAT);

    // Randomised mix
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      bit v, clr, rn;
      logic [31:0] w;
      r   = $urandom_range(0, 99);
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 49) == 0);
      rn  = ($urandom_range(0, 199) != 0);
      if (r < 90)      w = g;
      else if (r < 95) w = g ^ (32'd1 << $urandom_range(0, 31));
      else if (r < 98) w = $urandom;
      else             w = 32'd0;
      if (r >= 95 && r < 98 && $urandom_range(0, 1) == 1) g = $urandom | 32'd1;
      cyc(v, w, clr, rn);
      if (v && r < 95) g = nx(g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
